// File: rtl/uart_rx_frame_buffer_pkg.sv
// Shared definitions for the UART receive frame buffer: acknowledge FSM
// encoding and the frame-width rule shared with the UART controller.

`ifndef UART_RX_FRAME_W
`define UART_RX_FRAME_W(bytes) ((bytes) << 3)
`endif

package uart_rx_frame_buffer_pkg;

  localparam logic [1:0] A_IDLE_ENC = 2'b00;
  localparam logic [1:0] A_ACK_ENC  = 2'b01;
  localparam logic [1:0] A_REL_ENC  = 2'b10;

  typedef enum logic [1:0] {
    A_IDLE = A_IDLE_ENC,
    A_ACK  = A_ACK_ENC,
    A_REL  = A_REL_ENC
  } ack_state_t;

  localparam int FRM_CNT_W = 16;

endpackage

// File: rtl/uart_rx_frame_buffer_if.sv
// Frame handshake bundle: controller-side rx_data/rx_rdy/rx_ack and the
// application-side valid/ready head-of-queue port.

interface uart_rx_frame_buffer_if #(
  parameter int W = 64
);
  logic [W-1:0] rx_data;
  logic         rx_rdy;
  logic         rx_ack;
  logic [W-1:0] m_data;
  logic         m_vld;
  logic         m_rdy;

  // The frame buffer itself.
  modport slave (
    input  rx_data,
    input  rx_rdy,
    input  m_rdy,
    output rx_ack,
    output m_data,
    output m_vld
  );

  // The environment: controller and application driving the buffer.
  modport master (
    output rx_data,
    output rx_rdy,
    output m_rdy,
    input  rx_ack,
    input  m_data,
    input  m_vld
  );
endinterface

// File: rtl/uart_rx_frame_buffer_frame_fifo.sv
// Power-of-two frame FIFO with wrapping pointers and an explicit occupancy
// register. Head data is read straight out of storage; callers gate it.

module uart_rx_frame_buffer_frame_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Never overfill or underflow, even if a caller misbehaves.
  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop && (level != '0);

  assign head_data = mem[rd_ptr];

  // Storage is intentionally left unreset; empty reads are gated upstream.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally; level tracks push/pop balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Receive-side frame buffer between the UART controller and the command
// decoder: acknowledges each completed frame exactly once, queues it, and
// presents the oldest frame on a valid/ready port.

module uart_rx_frame_buffer
  import uart_rx_frame_buffer_pkg::*;
#(
  parameter int RX_DATA_BYTE_WIDTH = 8,
  parameter int DEPTH              = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_rx_frame_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic [FRM_CNT_W-1:0]    frm_cnt
);
  localparam int W  = `UART_RX_FRAME_W(RX_DATA_BYTE_WIDTH);
  localparam int LW = $clog2(DEPTH) + 1;

  ack_state_t           state;
  logic                 rx_ack_q;
  logic [FRM_CNT_W-1:0] frm_cnt_q;
  logic                 push;
  logic                 pop;
  logic                 not_empty;
  logic [W-1:0]         head_data;

  // Eligibility uses the registered level, so a same-cycle pop cannot
  // unblock a waiting frame until the following edge.
  assign push      = (state == A_IDLE) && bus.rx_rdy && (level != LW'(DEPTH));
  assign not_empty = (level != '0);
  assign pop       = not_empty && bus.m_rdy;

  uart_rx_frame_buffer_frame_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) frame_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.rx_data),
    .pop       (pop),
    .head_data (head_data),
    .level     (level)
  );

  // Acknowledge FSM: one capture and one ack pulse per frame; A_REL waits
  // out the controller's release so a held rx_rdy is never captured twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= A_IDLE;
      rx_ack_q <= 1'b0;
    end else begin
      case (state)
        A_IDLE: begin
          if (push) begin
            state    <= A_ACK;
            rx_ack_q <= 1'b1;
          end else begin
            rx_ack_q <= 1'b0;
          end
        end
        A_ACK: begin
          rx_ack_q <= 1'b0;
          state    <= A_REL;
        end
        A_REL: begin
          rx_ack_q <= 1'b0;
          if (!bus.rx_rdy) state <= A_IDLE;
        end
        default: begin
          state    <= A_IDLE;
          rx_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of captured frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_q <= '0;
    end else if (push && (frm_cnt_q != '1)) begin
      frm_cnt_q <= frm_cnt_q + FRM_CNT_W'(1);
    end
  end

  assign bus.rx_ack = rx_ack_q;
  assign bus.m_vld  = not_empty;
  assign bus.m_data = not_empty ? head_data : '0;
  assign frm_cnt    = frm_cnt_q;
endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
// Self-checking bench for uart_rx_frame_buffer. Stimulus is applied and
// outputs sampled on the falling clock edge.

module tb_uart_rx_frame_buffer;
  localparam int BYTES = 8;
  localparam int W     = BYTES * 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  level;
  logic [15:0] frm_cnt;

  uart_rx_frame_buffer_if #(.W(W)) bus();

  uart_rx_frame_buffer #(
    .RX_DATA_BYTE_WIDTH (BYTES),
    .DEPTH              (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .level   (level),
    .frm_cnt (frm_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queue of accepted frames and a saturating counter.
  logic [W-1:0] model_q[$];
  int           model_cnt;

  function automatic void model_reset();
    model_q.delete();
    model_cnt = 0;
  endfunction

  function automatic void model_capture(input logic [W-1:0] d);
    model_q.push_back(d);
    if (model_cnt < 65535) model_cnt++;
  endfunction

  function automatic logic [W-1:0] model_head();
    return (model_q.size() != 0) ? model_q[0] : '0;
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = '0;
    bus.m_rdy   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Controller model: present a frame, wait for ack, hold rx_rdy for
  // 1+hold more cycles, release, and idle one cycle. lat is cycles from
  // presentation to ack (-1 on timeout); extra counts further ack pulses.
  task automatic send_frame(input logic [W-1:0] d, input int hold,
                            output int lat, output int extra);
    lat   = -1;
    extra = 0;
    bus.rx_data = d;
    bus.rx_rdy  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.rx_ack) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) model_capture(d);
    repeat (1 + hold) begin
      @(negedge clk);
      if (bus.rx_ack) extra++;
    end
    bus.rx_rdy = 1'b0;
    @(negedge clk);
    if (bus.rx_ack) extra++;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.rx_ack !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ack: got %b want 0", bus.rx_ack); end
    n_cmp++; if (bus.m_vld !== 1'b0) begin n_fail++; $display("FAIL reset_m_vld: got %b want 0", bus.m_vld); end
    n_cmp++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (frm_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frm_cnt: got %0d want 0", frm_cnt); end
  endtask

  task automatic test_single();
    int lat, extra;
    logic [W-1:0] d;
    do_reset();
    d = 64'h0123_4567_89AB_CDEF;
    send_frame(d, 0, lat, extra);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL single_ack_latency: got %0d want 1", lat); end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL single_ack_width: extra pulses %0d want 0", extra); end
    n_cmp++; if (bus.m_vld !== 1'b1) begin n_fail++; $display("FAIL single_m_vld: got %b want 1", bus.m_vld); end
    n_cmp++; if (bus.m_data !== model_head()) begin n_fail++; $display("FAIL single_m_data: got %h want %h", bus.m_data, model_head()); end
    n_cmp++; if (level !== 3'(model_q.size())) begin n_fail++; $display("FAIL single_level: got %0d want %0d", level, model_q.size()); end
    n_cmp++; if (frm_cnt !== 16'(model_cnt)) begin n_fail++; $display("FAIL single_frm_cnt: got %0d want %0d", frm_cnt, model_cnt); end
    bus.m_rdy = 1'b1;
    @(negedge clk);
    bus.m_rdy = 1'b0;
    void'(model_q.pop_front());
    n_cmp++; if (bus.m_data !== model_head()) begin n_fail++; $display("FAIL single_pop_data: got %h want %h", bus.m_data, model_head()); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_hold_high();
    int lat, extra;
    logic [W-1:0] d;
    do_reset();
    d = {$urandom, $urandom};
    send_frame(d, 10, lat, extra);
    n_cmp++; if (lat !== 1 || extra !== 0) begin n_fail++; $display("FAIL hold_ack_count: lat %0d extra %0d want lat 1 extra 0", lat, extra); end
    n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL hold_level: got %0d want 1", level); end
    n_cmp++; if (frm_cnt !== 16'd1) begin n_fail++; $display("FAIL hold_frm_cnt: got %0d want 1", frm_cnt); end
    n_cmp++; if (bus.m_data !== d) begin n_fail++; $display("FAIL hold_m_data: got %h want %h", bus.m_data, d); end
  endtask

  task automatic test_no_bypass();
    logic [W-1:0] d;
    do_reset();
    d = {$urandom, $urandom};
    bus.m_rdy   = 1'b1;
    bus.rx_data = d;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.m_vld !== 1'b1 || bus.m_data !== d || bus.rx_ack !== 1'b1) begin
      n_fail++; $display("FAIL nobypass_first: vld %b ack %b data %h want 1 1 %h", bus.m_vld, bus.rx_ack, bus.m_data, d);
    end
    @(negedge clk);
    n_cmp++; if (bus.m_vld !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL nobypass_drained: vld %b level %0d want 0 0", bus.m_vld, level); end
    bus.rx_rdy = 1'b0;
    bus.m_rdy  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_stall();
    int lat, extra, acks;
    logic [W-1:0] exp_d;
    do_reset();
    for (int v = 1; v <= DEPTH; v++) begin
      send_frame(W'(v), $urandom_range(0, 2), lat, extra);
      n_cmp++; if (lat !== 1 || extra !== 0) begin n_fail++; $display("FAIL stall_fill_ack: frame %0d lat %0d extra %0d want 1 0", v, lat, extra); end
    end
    bus.rx_data = W'(5);
    bus.rx_rdy  = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rx_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL stall_no_ack: got %0d acks want 0", acks); end
    n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL stall_level: got %0d want 4", level); end
    n_cmp++; if (bus.m_data !== W'(1)) begin n_fail++; $display("FAIL stall_head: got %h want 1", bus.m_data); end
    bus.m_rdy = 1'b1;
    @(negedge clk);
    bus.m_rdy = 1'b0;
    void'(model_q.pop_front());
    n_cmp++; if (bus.m_data !== W'(2) || level !== 3'd3 || bus.rx_ack !== 1'b0) begin
      n_fail++; $display("FAIL stall_after_pop: data %h level %0d ack %b want 2 3 0", bus.m_data, level, bus.rx_ack);
    end
    @(negedge clk);
    n_cmp++; if (bus.rx_ack !== 1'b1 || level !== 3'd4) begin n_fail++; $display("FAIL stall_late_ack: ack %b level %0d want 1 4", bus.rx_ack, level); end
    if (bus.rx_ack) model_capture(W'(5));
    bus.rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    bus.m_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = model_head();
      n_cmp++; if (bus.m_data !== exp_d) begin n_fail++; $display("FAIL stall_drain: item %0d got %h want %h", k, bus.m_data, exp_d); end
      if (model_q.size() != 0) void'(model_q.pop_front());
      @(negedge clk);
    end
    bus.m_rdy = 1'b0;
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL stall_drain_level: got %0d want 0", level); end
  endtask

  task automatic test_order_wrap();
    logic [W-1:0] exp_seq [10];
    int got;
    do_reset();
    for (int i = 0; i < 10; i++) exp_seq[i] = W'(i + 1);
    got = 0;
    fork
      begin
        int lat, extra;
        for (int i = 0; i < 10; i++) begin
          send_frame(exp_seq[i], $urandom_range(0, 2), lat, extra);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int c = 0; c < 1000 && got < 10; c++) begin
          bus.m_rdy = ($urandom_range(0, 2) != 0);
          if (bus.m_vld && bus.m_rdy) begin
            n_cmp++; if (bus.m_data !== exp_seq[got]) begin n_fail++; $display("FAIL order_data: item %0d got %h want %h", got, bus.m_data, exp_seq[got]); end
            got++;
          end
          @(negedge clk);
        end
        bus.m_rdy = 1'b0;
      end
    join
    n_cmp++; if (got !== 10) begin n_fail++; $display("FAIL order_count: got %0d frames want 10", got); end
    model_q.delete();
    n_cmp++; if (level !== 3'd0 || bus.m_vld !== 1'b0 || bus.m_data !== '0) begin
      n_fail++; $display("FAIL order_empty: level %0d vld %b data %h want 0 0 0", level, bus.m_vld, bus.m_data);
    end
    n_cmp++; if (frm_cnt !== 16'd10) begin n_fail++; $display("FAIL order_frm_cnt: got %0d want 10", frm_cnt); end
  endtask

  task automatic test_reset_mid_ack();
    int lat, extra;
    logic [W-1:0] d3;
    do_reset();
    for (int i = 0; i < 2; i++) send_frame({$urandom, $urandom}, 0, lat, extra);
    d3 = {$urandom, $urandom};
    bus.rx_data = d3;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rx_ack !== 1'b1 || level !== 3'd3) begin n_fail++; $display("FAIL midack_pre: ack %b level %0d want 1 3", bus.rx_ack, level); end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (bus.rx_ack !== 1'b0 || bus.m_vld !== 1'b0 || bus.m_data !== '0) begin
      n_fail++; $display("FAIL midack_outputs: ack %b vld %b data %h want 0 0 0", bus.rx_ack, bus.m_vld, bus.m_data);
    end
    n_cmp++; if (level !== 3'd0 || frm_cnt !== 16'd0) begin n_fail++; $display("FAIL midack_counts: level %0d frm_cnt %0d want 0 0", level, frm_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_capture(d3);
    n_cmp++; if (bus.rx_ack !== 1'b1 || bus.m_data !== model_head() || frm_cnt !== 16'(model_cnt)) begin
      n_fail++; $display("FAIL midack_recapture: ack %b data %h cnt %0d want 1 %h %0d", bus.rx_ack, bus.m_data, frm_cnt, model_head(), model_cnt);
    end
    bus.rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturation();
    int lat, extra;
    do_reset();
    bus.m_rdy = 1'b1;
    force dut.frm_cnt_q = 16'hFFF8;
    @(negedge clk);
    release dut.frm_cnt_q;
    model_cnt = 16'hFFF8;
    for (int i = 1; i <= 12; i++) begin
      send_frame({$urandom, $urandom}, 0, lat, extra);
      if (i == 5) begin
        n_cmp++; if (frm_cnt !== 16'(model_cnt)) begin n_fail++; $display("FAIL sat_midway: got %h want %h", frm_cnt, model_cnt); end
      end
    end
    n_cmp++; if (frm_cnt !== 16'(model_cnt)) begin n_fail++; $display("FAIL sat_final: got %h want %h", frm_cnt, model_cnt); end
    bus.m_rdy = 1'b0;
    model_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = '0;
    bus.m_rdy   = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_hold_high();
    test_no_bypass();
    test_full_stall();
    test_order_wrap();
    test_reset_mid_ack();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_buffer.md
# uart_rx_frame_buffer

Receive-side consumer of the UART controller's frame handshake. Accepts completed multi-byte frames presented on `rx_data`/`rx_rdy`, returns a one-cycle `rx_ack`, and queues frames in a small FIFO. Frames are handed to the application through a valid/ready port. The block sits between the UART controller's receive port and the command decoder, so the controller sits in its wait state only while this buffer is full.

## Interface
- `RX_DATA_BYTE_WIDTH`, 8: bytes per frame. Frame width `W = RX_DATA_BYTE_WIDTH*8`.
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and ≥2.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in W: frame from the controller, MSB byte received first.
- `rx_rdy` in 1: frame complete. Held high until acknowledged.
- `rx_ack` out 1: registered one-cycle acknowledge to the controller.
- `m_data` out W: head-of-FIFO frame. Zero when empty.
- `m_vld` out 1: FIFO non-empty.
- `m_rdy` in 1: application accepts the head frame.
- `level` out clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `frm_cnt` out 16: frames accepted since reset. Saturates at 0xFFFF.

## Operation
- Acknowledge FSM has three states:
  - `A_IDLE`: if `rx_rdy & (level<DEPTH)`, capture `rx_data` into the FIFO, set `rx_ack<=1`, and go to `A_ACK`. If the FIFO is full, stay, keep `rx_ack=0`, and do not capture.
  - `A_ACK`: `rx_ack<=0` and go to `A_REL`. `rx_rdy` is still high in this cycle and must be ignored.
  - `A_REL`: wait until `rx_rdy==0`, then go to `A_IDLE`. This guarantees exactly one capture per frame, whatever the controller's release latency.
  - Encoding 2'b00/01/10. The illegal value 2'b11 goes to `A_IDLE` with `rx_ack=0`.
- FIFO behaviour:
  - Write pointer, read pointer and `level` registers.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - Push happens on capture. Pop happens when `m_vld & m_rdy`.
  - `level` rule: push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
- Full/empty boundaries:
  - Push eligibility uses the registered `level`. A pop in the same cycle as a full-blocked `rx_rdy` does not enable a push that cycle; the push happens on the next cycle.
  - A push into an empty FIFO while `m_rdy=1` takes two cycles to drain. There is no bypass path.
- `frm_cnt` increments on each capture and stops at 0xFFFF.
- `m_data = m_vld ? mem[rd_ptr] : 0`, driven combinationally from storage.
- Reset values: `rx_ack=0`, `m_vld=0`, `m_data=0`, `level=0`, `frm_cnt=0`, FSM in `A_IDLE`, pointers 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all queued frames and any in-progress acknowledge.
  - If `rx_rdy` is high after reset release, that frame is captured again.

## Timing
- Capture edge t, when `A_IDLE` sees `rx_rdy=1` and the FIFO is not full:
  - Edge t: frame written, `level` and `frm_cnt` updated.
  - Cycle t+1: `rx_ack=1` and `m_vld=1` if the FIFO was empty.
  - Cycle t+2: `rx_ack=0`.
  - Earliest next capture: edge t+2 sees `A_REL`. With the controller, `rx_rdy` is low by t+2, so the FSM returns to `A_IDLE` by edge t+3.
- `rx_ack` is never high for more than one cycle.
- `rx_ack` is never asserted while `rx_rdy` is low.
- Pop: `m_data`/`m_vld` reflect the next entry one cycle after the accepting edge.
- Throughput: at most one frame accepted every 3 cycles, far above the UART frame rate.

## Structure
- Shared package holds:
  - The `A_IDLE`/`A_ACK`/`A_REL` localparams.
  - The frame-width macro `(RX_DATA_BYTE_WIDTH << 3)`, matching the controller's width rule.
- One sub-module, `frame_fifo`:
  - Parameters: width, depth.
  - Ports: push, push_data, pop, head_data, level.
  - The top level contains only the acknowledge FSM, the frame counter and output gating.

## Test plan
- Single frame: reset; present `rx_data=64'h0123_4567_89AB_CDEF` with `rx_rdy` held until ack, dropping one cycle after ack.
  - Expect one `rx_ack` pulse one cycle after capture.
  - Expect `m_vld=1`, `m_data=64'h0123_4567_89AB_CDEF`, `level=1`, `frm_cnt=1`.
- Hold-high guard: keep `rx_rdy=1` for 10 cycles after ack → exactly one capture, `level=1`, `frm_cnt=1`.
- Full stall: `m_rdy=0`; push 4 frames (values 1..4), then present frame 5.
  - Expect `rx_ack` to stay 0 and `level=4`.
  - Pulse `m_rdy` once: `m_data` goes from 1 to 2. Frame 5 is acked on the cycle after the pop edge.
- Ordering and wrap: push and pop 10 frames with random `m_rdy` gaps → output sequence 1..10 in order, `level` returns to 0, `m_data=0`.
- Reset mid-ack: assert `rst_n=0` during the `A_ACK` cycle with 2 frames queued → all outputs at reset values immediately (asynchronous), `level=0`.
- Saturation: force 65,540 captures → `frm_cnt=0xFFFF`, no wrap to 0.
